// File: rtl/button_event_encoder_pkg.sv
// -----------------------------------------------------------------------------
// button_event_encoder_pkg
// Shared definitions for the button event encoder:
//   - chan_state_e : per-channel FSM encoding (IDLE / HOLD / REPEAT)
//   - DEF_HOLD_CYC : default press-to-first-repeat delay in clk cycles (500 ms @100 MHz)
//   - DEF_REP_CYC  : default repeat period in clk cycles (100 ms @100 MHz)
//   - DEF_TW       : default timer width, holds max(DEF_HOLD_CYC, DEF_REP_CYC)-1
// -----------------------------------------------------------------------------
package button_event_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } chan_state_e;

  localparam int unsigned DEF_HOLD_CYC = 50_000_000;
  localparam int unsigned DEF_REP_CYC  = 10_000_000;
  localparam int unsigned DEF_TW       = 26;

endpackage : button_event_encoder_pkg

// File: rtl/button_event_encoder_key_repeat_channel.sv
// -----------------------------------------------------------------------------
// key_repeat_channel
// One button channel: edge detect, hold/repeat timing FSM and a single-entry
// pending slot that the top-level arbiter drains.
// Ports:
//   i_clk      : system clock
//   i_reset    : synchronous, active-high reset
//   i_level    : debounced button level, 1 = pressed
//   i_grant    : arbiter takes the pending event this cycle
//   o_pend     : an event is waiting for the arbiter
//   o_pend_rep : repeat flag of the waiting event (0 = press, 1 = auto-repeat)
//   o_held     : FSM is not IDLE
//   o_overrun  : sticky, an event was dropped because the slot was occupied
// -----------------------------------------------------------------------------
module key_repeat_channel
  import button_event_encoder_pkg::*;
#(
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned REP_CYC  = DEF_REP_CYC,
  parameter int unsigned TW       = DEF_TW
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_level,
  input  logic i_grant,
  output logic o_pend,
  output logic o_pend_rep,
  output logic o_held,
  output logic o_overrun
);

  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REP_CYC - 1);

  chan_state_e   r_state;
  chan_state_e   w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic          r_prev;
  logic          r_pend;
  logic          r_pend_rep;
  logic          r_overrun;
  logic          w_raise;
  logic          w_raise_rep;

  // Next-state / timer / event-raise logic.
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_raise     = 1'b0;
    w_raise_rep = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_level && !r_prev) begin
          w_raise     = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!i_level) begin
          w_timer_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_timer == HOLD_LAST) begin
          w_raise     = 1'b1;
          w_raise_rep = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = ST_REPEAT;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_REPEAT: begin
        if (!i_level) begin
          w_timer_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_timer == REP_LAST) begin
          w_raise     = 1'b1;
          w_raise_rep = 1'b1;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      default: begin
        w_timer_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      // Loading the live level means a button already down out of reset is
      // treated as "seen" and produces no press event.
      r_prev     <= i_level;
      r_pend     <= 1'b0;
      r_pend_rep <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_prev  <= i_level;
      if (w_raise) begin
        if (r_pend && !i_grant) begin
          // Slot still occupied: drop the new event, keep the old one.
          r_overrun <= 1'b1;
        end else begin
          // A raise in the same cycle as a grant refills the slot.
          r_pend     <= 1'b1;
          r_pend_rep <= w_raise_rep;
        end
      end else if (i_grant) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_pend     = r_pend;
  assign o_pend_rep = r_pend_rep;
  assign o_held     = (r_state != ST_IDLE);
  assign o_overrun  = r_overrun;

endmodule : key_repeat_channel

// File: rtl/button_event_encoder.sv
// -----------------------------------------------------------------------------
// button_event_encoder
// Turns debounced button levels into press and auto-repeat key events, one at a
// time, lowest button index first, on a valid/ready output port.
// Ports:
//   i_clk        : system clock, 100 MHz
//   i_reset      : synchronous, active-high reset
//   i_btn_level  : [NB] debounced held levels, 1 = pressed
//   o_key_valid  : event available
//   o_key_code   : [CW] index of the button that generated the event
//   o_key_repeat : 0 = initial press, 1 = auto-repeat
//   i_key_ready  : consumer accepts when o_key_valid && i_key_ready
//   o_held       : [NB] per-channel FSM not IDLE
//   o_overrun    : [NB] sticky, event dropped because the channel was pending
// -----------------------------------------------------------------------------
module button_event_encoder
  import button_event_encoder_pkg::*;
#(
  parameter int unsigned NB       = 4,
  parameter int unsigned CW       = 2,
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned REP_CYC  = DEF_REP_CYC,
  parameter int unsigned TW       = DEF_TW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [NB-1:0] i_btn_level,
  output logic          o_key_valid,
  output logic [CW-1:0] o_key_code,
  output logic          o_key_repeat,
  input  logic          i_key_ready,
  output logic [NB-1:0] o_held,
  output logic [NB-1:0] o_overrun
);

  logic [NB-1:0] w_pend;
  logic [NB-1:0] w_pend_rep;
  logic [NB-1:0] w_grant;
  logic [NB-1:0] w_pick_onehot;
  logic [CW-1:0] w_pick_idx;
  logic          w_pick_valid;
  logic          w_pick_rep;
  logic          w_load;

  logic          r_key_valid;
  logic [CW-1:0] r_key_code;
  logic          r_key_repeat;

  for (genvar g = 0; g < NB; g++) begin : g_chan
    key_repeat_channel #(
      .HOLD_CYC (HOLD_CYC),
      .REP_CYC  (REP_CYC),
      .TW       (TW)
    ) u_chan (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_level    (i_btn_level[g]),
      .i_grant    (w_grant[g]),
      .o_pend     (w_pend[g]),
      .o_pend_rep (w_pend_rep[g]),
      .o_held     (o_held[g]),
      .o_overrun  (o_overrun[g])
    );
  end

  // The output register is free when empty or being drained this cycle.
  assign w_load = !r_key_valid || i_key_ready;

  // Lowest-index pick: scan downwards so the lowest pending index is written last.
  always_comb begin
    w_pick_valid  = 1'b0;
    w_pick_idx    = '0;
    w_pick_rep    = 1'b0;
    w_pick_onehot = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_pick_valid  = 1'b1;
        w_pick_idx    = CW'(i);
        w_pick_rep    = w_pend_rep[i];
        w_pick_onehot = '0;
        w_pick_onehot[i] = 1'b1;
      end
    end
  end

  assign w_grant = w_load ? w_pick_onehot : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_key_valid  <= 1'b0;
      r_key_code   <= '0;
      r_key_repeat <= 1'b0;
    end else if (w_load) begin
      r_key_valid <= w_pick_valid;
      if (w_pick_valid) begin
        r_key_code   <= w_pick_idx;
        r_key_repeat <= w_pick_rep;
      end
    end
  end

  assign o_key_valid  = r_key_valid;
  assign o_key_code   = r_key_code;
  assign o_key_repeat = r_key_repeat;

endmodule : button_event_encoder
